// File: rtl/pipelined_carry_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_carry_adder_if
//  Description : Operand/result bundle for the pipelined carry adder.
//                master drives operations and reads results; slave is the
//                adder side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_carry_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub,
        input  out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub,
        output out_valid, sum, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_carry_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_carry_adder
//  Description : Pipelined ripple-carry adder/subtractor. Each stage ripples
//                one SEG-bit segment and registers its carry for the next
//                stage; result appears STAGES cycles after the operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_carry_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    pipelined_carry_adder_if.slave  bus
);
    localparam int STAGES = WIDTH / SEG;

    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;
    logic             r_cmsb;

    // Subtraction is a + ~b + 1; cin only matters for addition.
    always_comb begin
        w_b_eff = bus.sub ? ~bus.b : bus.b;
        w_c0    = bus.sub | bus.cin;
    end

    // Stage k sees only the operand bits not yet consumed (skew) and carries
    // the sum bits already produced (de-skew), so both shrink/grow per stage.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int R_IN = WIDTH - k * SEG;
        localparam int DONE = (k + 1) * SEG;

        logic            w_v_in;
        logic [R_IN-1:0] w_a_in;
        logic [R_IN-1:0] w_b_in;
        logic            w_c_in;
        logic [SEG:0]    w_seg;
        logic [DONE-1:0] w_s_nxt;

        logic            r_vld;
        logic            r_c;
        logic [DONE-1:0] r_s;

        if (k == 0) begin : g_head
            assign w_v_in  = bus.in_valid;
            assign w_a_in  = bus.a;
            assign w_b_in  = w_b_eff;
            assign w_c_in  = w_c0;
            assign w_s_nxt = w_seg[SEG-1:0];
        end else begin : g_body
            assign w_v_in  = g_stage[k-1].r_vld;
            assign w_a_in  = g_stage[k-1].g_skew.r_a;
            assign w_b_in  = g_stage[k-1].g_skew.r_b;
            assign w_c_in  = g_stage[k-1].r_c;
            assign w_s_nxt = {w_seg[SEG-1:0], g_stage[k-1].r_s};
        end

        // Ripple this stage's segment (lowest SEG bits of the remaining operand).
        always_comb begin
            w_seg = {1'b0, w_a_in[SEG-1:0]} + {1'b0, w_b_in[SEG-1:0]}
                  + {{SEG{1'b0}}, w_c_in};
        end

        // Valid moves every cycle; sum/carry load only with a valid operation.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_c   <= 1'b0;
                r_s   <= '0;
            end else begin
                r_vld <= w_v_in;
                if (w_v_in) begin
                    r_c <= w_seg[SEG];
                    r_s <= w_s_nxt;
                end
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [R_IN-SEG-1:0] r_a;
            logic [R_IN-SEG-1:0] r_b;

            // Forward the unconsumed operand bits to the next stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_v_in) begin
                    r_a <= w_a_in[R_IN-1:SEG];
                    r_b <= w_b_in[R_IN-1:SEG];
                end
            end
        end
    end

    // Carry into the MSB, recovered as a ^ b ^ sum at the top bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmsb <= 1'b0;
        end else if (g_stage[STAGES-1].w_v_in) begin
            r_cmsb <= g_stage[STAGES-1].w_a_in[SEG-1]
                    ^ g_stage[STAGES-1].w_b_in[SEG-1]
                    ^ g_stage[STAGES-1].w_seg[SEG-1];
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].r_vld;
    assign bus.sum       = g_stage[STAGES-1].r_s;
    assign bus.cout      = g_stage[STAGES-1].r_c;
    assign bus.ovf       = r_cmsb ^ g_stage[STAGES-1].r_c;

endmodule
`default_nettype wire
